// File: rtl/nand4_seq_ctrl.sv
// nand4_seq_ctrl: walks all 16 nand4 input vectors, checks e/f/g against the golden function.
// Define NAND4_SEQ_ERRSTOP_EN to end the run at the first mismatching vector.
module nand4_seq_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);
  typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d, fvec_q, fvec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic       busy_q, busy_d, pass_q, pass_d, fv_q, fv_d;
  logic       exp_e, exp_f, exp_g, mism, last;
  // expected values come from the vector index, never from the observed e/f
  assign exp_e = ~(vec_q[3] & vec_q[2]);
  assign exp_f = ~(vec_q[1] & vec_q[0]);
  assign exp_g = ~(exp_e & exp_f);
  assign mism  = {e, f, g} != {exp_e, exp_f, exp_g};
`ifdef NAND4_SEQ_ERRSTOP_EN
  assign last = (vec_q == 4'd15) | mism;
`else
  assign last = vec_q == 4'd15;
`endif
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    busy_d  = busy_q;
    pass_d  = pass_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    case (state_q)
      IDLE: if (start) begin
        vec_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b1;
        err_d   = '0;
        fv_d    = 1'b0;
        fvec_d  = '0;
        pass_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'(SETTLE_CYCLES - 1)) ? CHECK : WAIT;
      end
      CHECK: begin
        if (mism) begin
          err_d = err_q + 5'd1;
          if (!fv_q) begin
            fv_d   = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (last) begin
          busy_d  = 1'b0;
          pass_d  = err_d == 5'd0;
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end
  assign {a, b, c, d} = vec_q;
  assign busy       = busy_q;
  assign done       = state_q == DONE;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
endmodule

// File: tb/tb_nand4_seq_ctrl.sv
// tb_nand4_seq_ctrl: two sequencers (S=2, S=1) driving modelled nand4 networks with injectable faults.
module tb_nand4_seq_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] st = '0;
  int mode[2] = '{0, 0};
  int S[2] = '{2, 1};
  int total = 0, passed = 0;
  logic [3:0] v0, v1, fvec0, fvec1;
  logic [4:0] err0, err1;
  logic e0, f0, g0, e1, f1, g1, busy0, busy1, done0, done1, pass0, pass1, fv0, fv1;
`ifdef NAND4_SEQ_ERRSTOP_EN
  localparam bit ERRSTOP = 1'b1;
`else
  localparam bit ERRSTOP = 1'b0;
`endif
  // mode 0: healthy gate, 1: e stuck at 0, 2: g stuck at 1
  assign e0 = mode[0] == 1 ? 1'b0 : ~(v0[3] & v0[2]);
  assign f0 = ~(v0[1] & v0[0]);
  assign g0 = mode[0] == 2 ? 1'b1 : ~(~(v0[3] & v0[2]) & f0);
  assign e1 = mode[1] == 1 ? 1'b0 : ~(v1[3] & v1[2]);
  assign f1 = ~(v1[1] & v1[0]);
  assign g1 = mode[1] == 2 ? 1'b1 : ~(~(v1[3] & v1[2]) & f1);
  nand4_seq_ctrl #(.SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .e(e0), .f(f0), .g(g0),
    .a(v0[3]), .b(v0[2]), .c(v0[1]), .d(v0[0]), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_valid(fv0), .fail_vec(fvec0));
  nand4_seq_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .e(e1), .f(f1), .g(g1),
    .a(v1[3]), .b(v1[2]), .c(v1[1]), .d(v1[0]), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1));
  function automatic logic [16:0] pk(int w);
    return w == 0 ? {v0, busy0, done0, pass0, err0, fv0, fvec0}
                  : {v1, busy1, done1, pass1, err1, fv1, fvec1};
  endfunction
  function automatic bit mis(int k, int m);
    bit ge = !(k[3] && k[2]);
    bit gf = !(k[1] && k[0]);
    bit gg = !(ge && gf);
    return m == 1 ? ge : m == 2 ? !gg : 1'b0;
  endfunction
  // expected outputs t cycles after the start edge: {vec,busy,done,pass,err,fail_valid,fail_vec}
  function automatic logic [16:0] model(bit valid, int t, int s, int m);
    int kf = 16, lastk, tend, err = 0, vec;
    if (!valid) return '0;
    for (int k = 15; k >= 0; k--) if (mis(k, m)) kf = k;
    lastk = (ERRSTOP && kf < 16) ? kf : 15;
    tend  = (lastk + 1) * (s + 1);
    vec   = t / (s + 1);
    if (vec > lastk) vec = lastk;
    for (int k = 0; k <= lastk; k++) if (mis(k, m) && (k + 1) * (s + 1) <= t) err++;
    return {4'(vec), t < tend, t == tend, t >= tend && err == 0, 5'(err), err > 0,
            err > 0 ? 4'(kf) : 4'd0};
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
  endtask
  bit valid[2];
  int t[2], mm[2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid[0] <= 1'b0;
      valid[1] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [16:0] x;
        x = model(valid[i], t[i], S[i], mm[i]);
        if (st[i] && x[12:11] == 2'b00) begin
          valid[i] <= 1'b1;
          t[i]     <= 0;
          mm[i]    <= mode[i];
        end else if (valid[i] && t[i] < 100000) t[i] <= t[i] + 1;
      end
    end
  end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) chk($sformatf("dut%0d outputs", i), pk(i), model(valid[i], t[i], S[i], mm[i]));
  task automatic run(input int w, input int rp, input int ab, output int cyc, output bit got);
    logic [16:0] o;
    cyc = 0;
    got = 1'b0;
    @(negedge clk);
    st[w] = 1'b1;
    @(posedge clk);
    while (!got && cyc < 200) begin
      @(negedge clk);
      st[w] = (cyc == rp);
      if (cyc == ab) begin
        rst_n = 1'b0;
        #1 chk("abort reset values", pk(w), 0);
        break;
      end
      o = pk(w);
      if (o[11]) got = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
  endtask
  initial begin
    int cyc;
    bit got;
    repeat (2) @(negedge clk);
    chk("reset state", pk(0), 0);
    rst_n = 1'b1;
    run(0, -1, -1, cyc, got);
    chk("golden done cycle", cyc, 48);
    chk("golden pass", pass0, 1);
    chk("golden err_cnt", err0, 0);
    chk("golden fail_valid", fv0, 0);
    mode[0] = 1;
    run(0, -1, -1, cyc, got);
    chk("e stuck done cycle", cyc, ERRSTOP ? 3 : 48);
    chk("e stuck err_cnt", err0, ERRSTOP ? 1 : 12);
    chk("e stuck fail_vec", fvec0, 0);
    chk("e stuck fail_valid", fv0, 1);
    chk("e stuck pass", pass0, 0);
    mode[0] = 0;
    run(0, 15, -1, cyc, got);
    chk("repulse done cycle", cyc, 48);
    chk("repulse pass", pass0, 1);
    run(0, -1, 21, cyc, got);
    chk("abort no done", got, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run(0, -1, -1, cyc, got);
    chk("after abort done cycle", cyc, 48);
    chk("after abort pass", pass0, 1);
    mode[0] = 2;
    run(0, -1, -1, cyc, got);
    chk("g stuck done cycle", cyc, ERRSTOP ? 3 : 48);
    chk("g stuck err_cnt", err0, ERRSTOP ? 1 : 9);
    chk("g stuck fail_vec", fvec0, 0);
    chk("g stuck pass", pass0, 0);
    run(1, -1, -1, cyc, got);
    chk("s1 done cycle", cyc, 32);
    chk("s1 pass", pass1, 1);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
